// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with a multi-cycle shift-add multiplier.
// Simple ops complete in one cycle; MUL iterates WIDTH times before presenting
// its result. Status flags are registered alongside the result.
//
// Handshake: an operation is accepted on a rising edge where in_valid && in_ready;
// a result is consumed on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, so the two never overlap.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4,
    parameter int SH_W   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow,
    output logic              illegal,
    output logic [1:0]        dbg_state
);

    localparam logic [FUNC_W-1:0] OP_ADD = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] OP_SUB = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] OP_AND = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] OP_OR  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] OP_XOR = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] OP_SLT = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] OP_SLL = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] OP_SRL = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] OP_SRA = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] OP_MUL = FUNC_W'(9);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [SH_W-1:0]      cnt;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic [WIDTH-1:0]     op_res;
    logic                 op_carry;
    logic                 op_ovf;
    logic                 op_ill;
    logic [SH_W-1:0]      sh_amt;
    logic [2*WIDTH-1:0]   acc_nxt;

    // Only the low SH_W bits of b select the shift distance.
    assign sh_amt = b[SH_W-1:0];

    // Single-cycle result and flags for every non-MUL opcode.
    always_comb begin
        sum_w    = {1'b0, a} + {1'b0, b};
        diff_w   = {1'b0, a} - {1'b0, b};
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_ill   = 1'b0;
        case (func)
            OP_ADD: begin
                op_res   = sum_w[WIDTH-1:0];
                op_carry = sum_w[WIDTH];
                op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res   = diff_w[WIDTH-1:0];
                // Top bit of the extended difference is the borrow; carry means a >= b.
                op_carry = ~diff_w[WIDTH];
                op_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  op_res = a << sh_amt;
            OP_SRL:  op_res = a >> sh_amt;
            OP_SRA:  op_res = $signed(a) >>> sh_amt;
            OP_MUL:  op_res = '0;
            default: op_ill = 1'b1;
        endcase
    end

    // One shift-add step: accumulate the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
    end

    // Control FSM plus registered datapath; outputs change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (func == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            result    <= op_res;
                            carry     <= op_carry;
                            overflow  <= op_ovf;
                            illegal   <= op_ill;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // The last iteration's addition is folded into the captured result.
                    if (cnt == SH_W'(WIDTH - 1)) begin
                        result    <= acc_nxt[WIDTH-1:0];
                        carry     <= |acc_nxt[2*WIDTH-1:WIDTH];
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign zero      = (result == '0);
    assign negative  = result[WIDTH-1];
    assign dbg_state = state;

endmodule
